// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 FSM type, round count and byte-level transforms
// byte i of a 128-bit block is [127-8i -: 8]; row = i%4, column = i/4
package aes_pkg;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
    localparam logic [3:0] NR = 4'd10;
    localparam logic [15:0] INV_MIX = 16'hebd9;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            p = k[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction
    // row r of each column uses the {0e,0b,0d,09} row rotated right by r
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    o[127-8*(4*c+r) -: 8] = o[127-8*(4*c+r) -: 8]
                        ^ gmul(s[127-8*(4*c+k) -: 8], INV_MIX[15-4*((k-r+4)%4) -: 4]);
        return o;
    endfunction
endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: combinational AES inverse S-box lookup
module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [7:0] TABLE [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
    assign o_byte = TABLE[i_byte];
endmodule

// File: rtl/inv_cipher_core.sv
// inv_cipher_core: iterative AES-128 inverse cipher, one round per clock
// round keys are fetched combinationally from an external store via rk_idx
module inv_cipher_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    state_t       r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_data_out;
    logic [3:0]   r_rnd;
    logic         r_out_valid;
    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;

    assign w_isr = inv_shift_rows(r_state);
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_sbox (.i_byte(w_isr[127-8*i -: 8]), .o_byte(w_isb[127-8*i -: 8]));
    end
    assign w_ark     = w_isb ^ rk_in;
    assign in_ready  = (r_fsm == IDLE) && !rst;
    assign busy      = r_fsm != IDLE;
    assign rk_idx    = (r_fsm == IDLE) ? NR : (r_fsm == ROUND) ? r_rnd : 4'd0;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_rnd       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: if (in_valid) begin
                    r_state <= data_in ^ rk_in;
                    r_rnd   <= NR - 4'd1;
                    r_fsm   <= ROUND;
                end
                ROUND: begin
                    r_state <= inv_mix_columns(w_ark);
                    if (r_rnd == 4'd1) r_fsm <= FINAL;
                    else r_rnd <= r_rnd - 4'd1;
                end
                FINAL: begin
                    r_data_out  <= w_ark;
                    r_out_valid <= 1'b1;
                    r_fsm       <= DONE;
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_fsm       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inv_cipher_core.sv
// tb_inv_cipher_core: scoreboard bench comparing the core against a byte-level
// FIPS-197 InvCipher model whose S-boxes are derived from GF(2^8) arithmetic
module tb_inv_cipher_core;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [7:0] IMC [4][4] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, busy, prev_ov;
    logic [127:0] data_in = '0, rk_in, data_out;
    logic [3:0] rk_idx;
    logic [127:0] keys [11];
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    logic [127:0] exp_q [$];
    int acc_q [$];
    int tests = 0, fails = 0, cyc = 0;

    inv_cipher_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .rk_idx(rk_idx), .rk_in(rk_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb rk_in = (rk_idx <= 4'd10) ? keys[rk_idx] : '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // carry-less product reduced modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
        return p[7:0];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h63;
            for (int i = 0; i < 8; i++)
                s[i] ^= inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endfunction

    function automatic void expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ keys[10][127-8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) t[4*((i/4 + i%4) % 4) + i%4] = isb[s[i]];
            for (int i = 0; i < 16; i++) t[i] ^= keys[r][127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) begin
                    s[4*c+row] = 8'h00;
                    for (int k = 0; k < 4; k++)
                        s[4*c+row] ^= (r > 0) ? gm(IMC[row][k], t[4*c+k]) : ((k == row) ? t[4*c+k] : 8'h00);
                end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    always @(negedge clk) begin
        if (rst) prev_ov <= 1'b0;
        else begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) check("spurious_out_valid", 128'(out_valid), 128'(0));
                else check("latency", 128'(cyc - acc_q.pop_front()), 128'(10));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", data_out, '0);
                else check("data_out", data_out, exp_q.pop_front());
                check("data_out_known", 128'($isunknown(data_out)), 128'(0));
            end
            prev_ov <= out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] ct);
        int n = 0;
        in_valid = 1'b1;
        data_in = ct;
        exp_q.push_back(model(ct));
        while (!in_ready && n < 50) begin tick(); n++; end
        check("accept_timeout", 128'(n < 50), 128'(1));
        tick();
        in_valid = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check("out_valid_timeout", 128'(n < 100), 128'(1));
    endtask

    initial begin
        int a0, a1;
        logic [127:0] ct2;
        build_sbox();
        expand(C1_KEY);
        repeat (2) tick();
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_data_out", data_out, '0);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(10));
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 128'(in_ready), 128'(1));

        // known answer with round-key index trace
        out_ready = 1'b1;
        send(C1_CT);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("rk_idx_e%0d", k), 128'(rk_idx), 128'(k < 9 ? 9 - k : 0));
            check("busy_in_flight", 128'(busy), 128'(1));
            tick();
        end
        check("c1_out_valid", 128'(out_valid), 128'(1));
        check("c1_plaintext", data_out, C1_PT);
        tick();
        check("idle_after_take", 128'(busy), 128'(0));

        // backpressure, with in_valid asserted while holding
        out_ready = 1'b0;
        send(C1_CT);
        wait_out();
        in_valid = 1'b1;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 20; k++) begin
            tick();
            check("bp_data_out", data_out, C1_PT);
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_busy", 128'(busy), 128'(1));
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_released", 128'(out_valid), 128'(0));

        // back-to-back blocks with in_valid and out_ready held high
        ct2 = C1_CT ^ 128'hff;
        in_valid = 1'b1;
        data_in = C1_CT;
        exp_q.push_back(model(C1_CT));
        a0 = cyc;
        tick();
        data_in = ct2;
        exp_q.push_back(model(ct2));
        a1 = 0;
        for (int n = 0; n < 30 && a1 == 0; n++) if (in_ready) a1 = cyc; else tick();
        tick();
        in_valid = 1'b0;
        check("b2b_accept_spacing", 128'(a1 - a0), 128'(12));
        wait_out();
        check("b2b_second_differs", 128'(data_out != C1_PT), 128'(1));
        tick();

        // reset on E5 of a block
        send(C1_CT);
        repeat (4) tick();
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_data_out", data_out, '0);
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        send(C1_CT);
        wait_out();
        check("post_rst_plaintext", data_out, C1_PT);
        tick();

        // all-zero round keys and ciphertext
        for (int r = 0; r < 11; r++) keys[r] = '0;
        send('0);
        wait_out();
        tick();
        expand(C1_KEY);

        // in_valid glitch at E3 while busy
        send(C1_CT);
        tick();
        tick();
        in_valid = 1'b1;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid = 1'b0;
        wait_out();
        check("glitch_plaintext", data_out, C1_PT);
        tick();

        // random keys, ciphertexts and sink stalls
        for (int t = 0; t < 20; t++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            out_ready = 1'b0;
            send({$urandom, $urandom, $urandom, $urandom});
            wait_out();
            repeat ($urandom_range(0, 4)) tick();
            out_ready = 1'b1;
            tick();
        end

        repeat (3) tick();
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inv_cipher_core.md
# inv_cipher_core

- Iterative AES-128 inverse cipher (FIPS-197 InvCipher): turns one 128-bit ciphertext block into plaintext, one round per clock.
- Mirror of the encryption datapath, whose final stage is SubBytes → ShiftRows → AddRoundKey. This block undoes that stage first, then runs the remaining inverse rounds.
- Sits between the ciphertext source and the plaintext sink. Uses valid/ready handshakes on both sides.
- Round keys come from an external key store, indexed by this block; key expansion is out of scope.

## Interface
Parameters:
- none (AES-128 fixed: Nr = 10).

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext block present.
- in_ready  out  1  block can accept; equals (state == IDLE) && !rst.
- data_in  in  128  ciphertext; byte 0 = [127:120], column-major per FIPS-197.
- rk_idx  out  4  round-key index requested this cycle, range 0..10.
- rk_in  in  128  round key for rk_idx; combinational lookup valid in the same cycle.
- out_valid  out  1  plaintext held in data_out.
- out_ready  in  1  sink accepts plaintext.
- data_out  out  128  plaintext; registered.
- busy  out  1  high in ROUND, FINAL, DONE.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. Registers: state[127:0], rnd[3:0].
- IDLE
  - rk_idx = 10.
  - On in_valid && in_ready: state ← data_in ^ rk_in, rnd ← 9, go to ROUND.
- ROUND
  - rk_idx = rnd.
  - state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_in)).
  - If rnd == 1, go to FINAL; otherwise rnd ← rnd − 1.
- FINAL
  - rk_idx = 0.
  - data_out ← InvSubBytes(InvShiftRows(state)) ^ rk_in.
  - out_valid ← 1, go to DONE.
- DONE
  - rk_idx = 0.
  - Hold data_out and out_valid stable.
  - On out_ready: out_valid ← 0, go to IDLE.
- InvShiftRows: row r rotates right by r bytes (row 0 unchanged).
- InvMixColumns: per column, matrix {0e,0b,0d,09} over GF(2^8) with polynomial 0x11B. All arithmetic is XOR and xtime; no carries and no width growth.
- in_valid is ignored outside IDLE. data_in is sampled only on the accepting edge.
- out_ready is ignored outside DONE.
- rst dominates every state and any in-flight block:
  - next edge: IDLE, out_valid = 0, data_out = 0, state = 0, rnd = 0;
  - the partial block is discarded; no output is produced for it.
- Reset values: in_ready 0 while rst is high, 1 on the first cycle after release; out_valid 0; data_out 0; busy 0; rk_idx 10.

## Timing
- E0 = accepting edge.
- Edges E1..E9 perform rounds 9..1; edge E10 performs the final round.
- out_valid is high from E10. Latency: 10 edges from accept to out_valid.
- Output handshake completes on the first edge with out_ready high in DONE; the block is IDLE after that edge.
- Minimum period with out_ready held high: 12 cycles per block (accept E0, output taken E11, next accept E12).
- No overlap: a new block is never accepted in the cycle the output is taken.
- rk_idx is a combinational function of state/rnd and is stable for the whole cycle. The key store must return rk_in in the same cycle.

## Structure
- Shared package aes_pkg:
  - state enum;
  - constant NR = 10;
  - functions xtime, gmul (small constants), inv_shift_rows, inv_mix_columns.
- Sub-module inv_sbox: 8-bit combinational inverse S-box table, instantiated 16× as an InvSubBytes array.
- The encryption path can later share aes_pkg.

## Test plan
- FIPS-197 C.1, key 000102030405060708090a0b0c0d0e0f:
  - ct 69c4e0d86a7b0430d8cdb78070b4c55a → data_out 00112233445566778899aabbccddeeff;
  - out_valid rises exactly 10 edges after accept;
  - rk_idx sequence is 10, 9, …, 1, 0.
- Backpressure: out_ready low for 20 cycles after out_valid → data_out, out_valid and busy held constant; in_valid asserted meanwhile is not accepted (in_ready 0).
- Back-to-back blocks, in_valid and out_ready held high:
  - C.1 ct, then the same ct with byte 15 flipped;
  - accepts at E0 and E12;
  - first output matches C.1; second differs from 00112233…eeff.
- Reset at E5 of a block:
  - after the next edge, out_valid 0, data_out 0, in_ready 1;
  - a subsequent C.1 decrypt is still correct.
- Key-index check: key store returns 0 for every index, ct = all-zero. Compare against a software InvCipher model run with all-zero round keys (not the FIPS zero-key expansion); no X is allowed on data_out.
- in_valid glitch while busy (high for 1 cycle at E3) → ignored; result unchanged and still produced at E10.
